// File: rtl/fib_seq_checker.sv
// fib_seq_checker: receive-side checker for the additive sequence generator.
// Recomputes the expected x sequence (x <= x+y while x < LIMIT, y <= x),
// compares every accepted sample against it, and reports the first mismatch,
// entry into the frozen region and per-sample threshold flags.
module fib_seq_checker #(
    parameter int          W      = 8,
    parameter int unsigned SEED   = 1,
    parameter int unsigned LIMIT  = 100,
    parameter int unsigned TARGET = 200,
    parameter int          CW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          ok,
    output logic          fail,
    output logic          frozen,
    output logic          hit,
    output logic          above,
    output logic [W-1:0]  bad_data,
    output logic [W-1:0]  exp_data,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        FAILED
    } state_t;

    localparam logic [W-1:0]  SEED_V   = W'(SEED);
    localparam logic [W-1:0]  TARGET_V = W'(TARGET);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    state_t        state, state_n;
    logic [W-1:0]  ex, ex_n;
    logic [W-1:0]  ey, ey_n;
    logic [CW-1:0] count_n;
    logic [W-1:0]  bad_data_n, exp_data_n;
    logic          hit_n, above_n;
    logic          accept;
    logic          growing;

    // LIMIT is compared at full 32-bit width so a LIMIT above 2^W means "always grow"
    assign growing  = (32'(ex) < LIMIT);
    assign accept   = in_valid && (state != FAILED);

    assign in_ready = (state != FAILED);
    assign ok       = (state == RUN) || (state == HOLD);
    assign fail     = (state == FAILED);
    assign frozen   = (state == HOLD);

    // Next-state logic: compare an accepted sample with ex and advance the model
    always_comb begin
        state_n    = state;
        ex_n       = ex;
        ey_n       = ey;
        count_n    = count;
        bad_data_n = bad_data;
        exp_data_n = exp_data;
        hit_n      = hit;
        above_n    = above;
        if (accept) begin
            count_n = (count == COUNT_MAX) ? count : count + CW'(1);
            hit_n   = (in_data == TARGET_V);
            above_n = (in_data > TARGET_V);
            if (in_data == ex) begin
                ey_n = ex;
                if (growing) begin
                    ex_n    = ex + ey;
                    state_n = RUN;
                end else begin
                    state_n = HOLD;
                end
            end else begin
                state_n    = FAILED;
                bad_data_n = in_data;
                exp_data_n = ex;
            end
        end
    end

    // State and output registers; reset and clear both restart the checker
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            ex       <= SEED_V;
            ey       <= SEED_V;
            count    <= '0;
            bad_data <= '0;
            exp_data <= '0;
            hit      <= 1'b0;
            above    <= 1'b0;
        end else begin
            state    <= state_n;
            ex       <= ex_n;
            ey       <= ey_n;
            count    <= count_n;
            bad_data <= bad_data_n;
            exp_data <= exp_data_n;
            hit      <= hit_n;
            above    <= above_n;
        end
    end

endmodule

// File: tb/tb_fib_seq_checker.sv
// tb_fib_seq_checker: scoreboard bench for fib_seq_checker.
// Four checker instances share one stimulus stream and differ in LIMIT and
// TARGET; a reference model predicts each instance's outputs per cycle.
module tb_fib_seq_checker;

    typedef struct {
        logic       ok;
        logic       fail;
        logic       frozen;
        logic       hit;
        logic       above;
        logic       ready;
        logic [7:0] bad;
        logic [7:0] expd;
        logic [5:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [7:0] in_data;

    logic       in_ready [4];
    logic       ok       [4];
    logic       fail     [4];
    logic       frozen   [4];
    logic       hit      [4];
    logic       above    [4];
    logic [7:0] bad_data [4];
    logic [7:0] exp_data [4];
    logic [5:0] count    [4];

    int unsigned lims [4] = '{100, 100, 100, 255};
    int unsigned tgts [4] = '{200, 144, 100, 200};

    int         mst   [4];
    logic [7:0] mex   [4];
    logic [7:0] mey   [4];
    logic [7:0] mbad  [4];
    logic [7:0] mexp  [4];
    logic [5:0] mcnt  [4];
    logic       mhit  [4];
    logic       mabove[4];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] golden [11] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144};

    always #5 clk = ~clk;

    fib_seq_checker #(.W(8), .SEED(1), .LIMIT(100), .TARGET(200), .CW(6)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .ok(ok[0]), .fail(fail[0]), .frozen(frozen[0]), .hit(hit[0]),
        .above(above[0]), .bad_data(bad_data[0]), .exp_data(exp_data[0]), .count(count[0]));

    fib_seq_checker #(.W(8), .SEED(1), .LIMIT(100), .TARGET(144), .CW(6)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .ok(ok[1]), .fail(fail[1]), .frozen(frozen[1]), .hit(hit[1]),
        .above(above[1]), .bad_data(bad_data[1]), .exp_data(exp_data[1]), .count(count[1]));

    fib_seq_checker #(.W(8), .SEED(1), .LIMIT(100), .TARGET(100), .CW(6)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[2]), .ok(ok[2]), .fail(fail[2]), .frozen(frozen[2]), .hit(hit[2]),
        .above(above[2]), .bad_data(bad_data[2]), .exp_data(exp_data[2]), .count(count[2]));

    fib_seq_checker #(.W(8), .SEED(1), .LIMIT(255), .TARGET(200), .CW(6)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[3]), .ok(ok[3]), .fail(fail[3]), .frozen(frozen[3]), .hit(hit[3]),
        .above(above[3]), .bad_data(bad_data[3]), .exp_data(exp_data[3]), .count(count[3]));

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model of one instance for one clock edge
    task automatic modelStep(input int k, input logic r, input logic c, input logic v, input logic [7:0] d);
        logic [7:0] sum;
        if (r || c) begin
            mst[k] = 0; mex[k] = 8'd1; mey[k] = 8'd1; mbad[k] = 8'd0; mexp[k] = 8'd0;
            mcnt[k] = 6'd0; mhit[k] = 1'b0; mabove[k] = 1'b0;
        end else if (v && mst[k] != 3) begin
            if (mcnt[k] != 6'd63) mcnt[k] = mcnt[k] + 6'd1;
            mhit[k]   = (32'(d) == tgts[k]);
            mabove[k] = (32'(d) > tgts[k]);
            if (d == mex[k]) begin
                if (32'(mex[k]) < lims[k]) begin
                    sum    = mex[k] + mey[k];
                    mey[k] = mex[k];
                    mex[k] = sum;
                    mst[k] = 1;
                end else begin
                    mey[k] = mex[k];
                    mst[k] = 2;
                end
            end else begin
                mst[k]  = 3;
                mbad[k] = d;
                mexp[k] = mex[k];
            end
        end
    endtask

    // Drive one cycle, push predictions, then compare them one clock later
    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic [7:0] d);
        exp_t e;
        reset = r; clear = c; in_valid = v; in_data = d;
        for (int k = 0; k < 4; k++) begin
            modelStep(k, r, c, v, d);
            e.ok     = (mst[k] == 1) || (mst[k] == 2);
            e.fail   = (mst[k] == 3);
            e.frozen = (mst[k] == 2);
            e.ready  = (mst[k] != 3);
            e.hit    = mhit[k];
            e.above  = mabove[k];
            e.bad    = mbad[k];
            e.expd   = mexp[k];
            e.cnt    = mcnt[k];
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            checkOutput($sformatf("u%0d.ok", k),       32'(ok[k]),       32'(e.ok));
            checkOutput($sformatf("u%0d.fail", k),     32'(fail[k]),     32'(e.fail));
            checkOutput($sformatf("u%0d.frozen", k),   32'(frozen[k]),   32'(e.frozen));
            checkOutput($sformatf("u%0d.in_ready", k), 32'(in_ready[k]), 32'(e.ready));
            checkOutput($sformatf("u%0d.hit", k),      32'(hit[k]),      32'(e.hit));
            checkOutput($sformatf("u%0d.above", k),    32'(above[k]),    32'(e.above));
            checkOutput($sformatf("u%0d.bad_data", k), 32'(bad_data[k]), 32'(e.bad));
            checkOutput($sformatf("u%0d.exp_data", k), 32'(exp_data[k]), 32'(e.expd));
            checkOutput($sformatf("u%0d.count", k),    32'(count[k]),    32'(e.cnt));
        end
    endtask

    task automatic sample(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic doClear();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic feedGolden();
        for (int i = 0; i < 11; i++) sample(golden[i]);
    endtask

    // Test sequence
    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd7);
        checkOutput("reset.in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("reset.count", 32'(count[0]), 32'd0);

        // Golden stream and thresholds
        feedGolden();
        checkOutput("t1.frozen_after_144", 32'(frozen[0]), 32'd1);
        sample(8'd144);
        sample(8'd144);
        checkOutput("t1.count", 32'(count[0]), 32'd13);
        checkOutput("t1.fail", 32'(fail[0]), 32'd0);
        checkOutput("t4.hit144", 32'(hit[1]), 32'd1);
        checkOutput("t4.above144", 32'(above[1]), 32'd0);
        checkOutput("t4.above100", 32'(above[2]), 32'd1);
        checkOutput("t4.hit100", 32'(hit[2]), 32'd0);

        // Counter saturation while holding
        for (int i = 0; i < 55; i++) sample(8'd144);
        checkOutput("sat.count", 32'(count[0]), 32'd63);
        checkOutput("sat.ok", 32'(ok[0]), 32'd1);

        // Hold violation
        sample(8'd145);
        checkOutput("t5.fail", 32'(fail[0]), 32'd1);
        checkOutput("t5.bad_data", 32'(bad_data[0]), 32'd145);
        checkOutput("t5.exp_data", 32'(exp_data[0]), 32'd144);
        checkOutput("t5.frozen", 32'(frozen[0]), 32'd0);

        // Mismatch in growth region
        doClear();
        sample(8'd1); sample(8'd2); sample(8'd4);
        checkOutput("t2.bad_data", 32'(bad_data[0]), 32'd4);
        checkOutput("t2.exp_data", 32'(exp_data[0]), 32'd3);
        checkOutput("t2.in_ready", 32'(in_ready[0]), 32'd0);
        checkOutput("t2.ok", 32'(ok[0]), 32'd0);
        sample(8'd9);
        checkOutput("t2.count_blocked", 32'(count[0]), 32'd3);

        // Gaps and clear
        doClear();
        sample(8'd1); idle(); idle(); sample(8'd2); sample(8'd3);
        checkOutput("t3.count", 32'(count[0]), 32'd3);
        checkOutput("t3.fail", 32'(fail[0]), 32'd0);
        doClear();
        sample(8'd1);
        checkOutput("t3.count_after_clear", 32'(count[0]), 32'd1);
        checkOutput("t3.ok_after_clear", 32'(ok[0]), 32'd1);
        checkOutput("t3.frozen_after_clear", 32'(frozen[0]), 32'd0);

        // Reset priority over clear and a valid sample
        sample(8'd2); sample(8'd3); sample(8'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd8);
        checkOutput("t6.count", 32'(count[0]), 32'd0);
        checkOutput("t6.ok", 32'(ok[0]), 32'd0);
        sample(8'd1);
        checkOutput("t6.restart_count", 32'(count[0]), 32'd1);

        // Wrap-around with LIMIT=255 on instance 3
        doClear();
        feedGolden();
        sample(8'd233); sample(8'd121); sample(8'd98);
        checkOutput("wrap.fail", 32'(fail[3]), 32'd0);
        checkOutput("wrap.count", 32'(count[3]), 32'd14);
        checkOutput("wrap.ok", 32'(ok[3]), 32'd1);
        checkOutput("wrap.other_fail", 32'(fail[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
